// File: rtl/operand_regfile_pkg.sv
// Shared default sizes and register index type for the operand register file.
package operand_regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/operand_regfile_rport.sv
// One operand read port: source mux, optional write bypass, registered capture.
// Optional feature macro: OPERAND_REGFILE_BYPASS_EN (forward same-cycle write data).
module operand_regfile_rport #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      ren,
    input  logic [$clog2(NREG)-1:0]   addr,
    input  logic [NREG-1:0][XLEN-1:0] regs,
    input  logic [NREG-1:0]           busy,
`ifdef OPERAND_REGFILE_BYPASS_EN
    input  logic                      rd_wen,
    input  logic [$clog2(NREG)-1:0]   rd,
    input  logic [XLEN-1:0]           rd_data,
    input  logic                      alloc_en,
    input  logic [$clog2(NREG)-1:0]   alloc_rd,
    input  logic                      flush,
`endif
    output logic                      rs_busy,
    output logic [XLEN-1:0]           rs_data,
    output logic                      rs_vld
);

    logic            src_busy;
    logic [XLEN-1:0] operand;
    logic            accept;

    assign src_busy = busy[addr] & (addr != '0);

`ifdef OPERAND_REGFILE_BYPASS_EN
    logic hit;
    logic realloc;

    // A write landing this cycle resolves the hazard, unless a newer producer re-marks it.
    assign hit     = rd_wen & (rd == addr) & (rd != '0);
    assign realloc = alloc_en & ~flush & (alloc_rd == addr);
    assign rs_busy = src_busy & ~(hit & ~realloc);
    assign operand = hit ? rd_data : regs[addr];
`else
    assign rs_busy = src_busy;
    assign operand = regs[addr];
`endif

    assign accept = ren & ~rs_busy;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rs_data <= '0;
            rs_vld  <= 1'b0;
        end else begin
            rs_vld <= accept;
            if (accept) begin
                rs_data <= operand;
            end
        end
    end

endmodule

// File: rtl/operand_regfile.sv
// Operand register file with pending-destination scoreboard and NRD registered read ports.
// Optional feature macro: OPERAND_REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module operand_regfile
    import operand_regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic                         rd_wen,
    input  logic [$clog2(NREG)-1:0]      rd,
    input  logic [XLEN-1:0]              rd_data,
    input  logic                         alloc_en,
    input  logic [$clog2(NREG)-1:0]      alloc_rd,
    input  logic                         flush,
    input  logic [NRD-1:0]               rs_ren,
    input  logic [NRD*$clog2(NREG)-1:0]  rs_addr,
    output logic [NRD-1:0]               rs_busy,
    output logic [NRD*XLEN-1:0]          rs_data,
    output logic [NRD-1:0]               rs_vld
);

    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][XLEN-1:0] x;
    logic [NREG-1:0]           busy;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            x <= '0;
        end else if (rd_wen && (rd != '0)) begin
            x[rd] <= rd_data;
        end
    end

    // Alloc is applied after the write-clear so a same-index issue keeps the mark.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (rd_wen) begin
                busy[rd] <= 1'b0;
            end
            if (alloc_en) begin
                busy[alloc_rd] <= 1'b1;
            end
            busy[0] <= 1'b0;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rport
        operand_regfile_rport #(
            .XLEN(XLEN),
            .NREG(NREG)
        ) u_rport (
            .CLK      (CLK),
            .RSTN     (RSTN),
            .ren      (rs_ren[i]),
            .addr     (rs_addr[i*AW +: AW]),
            .regs     (x),
            .busy     (busy),
`ifdef OPERAND_REGFILE_BYPASS_EN
            .rd_wen   (rd_wen),
            .rd       (rd),
            .rd_data  (rd_data),
            .alloc_en (alloc_en),
            .alloc_rd (alloc_rd),
            .flush    (flush),
`endif
            .rs_busy  (rs_busy[i]),
            .rs_data  (rs_data[i*XLEN +: XLEN]),
            .rs_vld   (rs_vld[i])
        );
    end

endmodule

// File: tb/tb_operand_regfile.sv
// Directed scoreboard bench for operand_regfile (default sizes, either bypass build).
module tb_operand_regfile;
    import operand_regfile_pkg::*;

    localparam int XLEN = XLEN_DEF;
    localparam int NREG = NREG_DEF;
    localparam int NRD  = NRD_DEF;
    localparam int AW   = AW_DEF;

    logic                   CLK;
    logic                   RSTN;
    logic                   rd_wen;
    reg_idx_t               rd;
    logic [XLEN-1:0]        rd_data;
    logic                   alloc_en;
    reg_idx_t               alloc_rd;
    logic                   flush;
    logic [NRD-1:0]         rs_ren;
    logic [NRD*AW-1:0]      rs_addr;
    logic [NRD-1:0]         rs_busy;
    logic [NRD*XLEN-1:0]    rs_data;
    logic [NRD-1:0]         rs_vld;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] q0[$];
    logic [XLEN-1:0] q1[$];

`ifdef OPERAND_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    operand_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .rd_wen   (rd_wen),
        .rd       (rd),
        .rd_data  (rd_data),
        .alloc_en (alloc_en),
        .alloc_rd (alloc_rd),
        .flush    (flush),
        .rs_ren   (rs_ren),
        .rs_addr  (rs_addr),
        .rs_busy  (rs_busy),
        .rs_data  (rs_data),
        .rs_vld   (rs_vld)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic wen, input int wr_idx, input logic [XLEN-1:0] wdata,
                                 input logic aen, input int a_idx, input logic fl,
                                 input logic [NRD-1:0] ren, input int addr0, input int addr1);
        rd_wen   = wen;
        rd       = reg_idx_t'(wr_idx);
        rd_data  = wdata;
        alloc_en = aen;
        alloc_rd = reg_idx_t'(a_idx);
        flush    = fl;
        rs_ren   = ren;
        rs_addr[0*AW +: AW] = reg_idx_t'(addr0);
        rs_addr[1*AW +: AW] = reg_idx_t'(addr1);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 2'b00, 0, 0);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Each port's valid must match whether the scoreboard holds an expected operand.
    task automatic checkPorts(input string tag);
        logic [XLEN-1:0] expv;
        logic            pending;
        for (int p = 0; p < NRD; p++) begin
            pending = (p == 0) ? (q0.size() != 0) : (q1.size() != 0);
            checkOutput($sformatf("%s_vld%0d", tag, p), 64'(rs_vld[p]), 64'(pending));
            if (pending) begin
                if (p == 0) expv = q0.pop_front();
                else        expv = q1.pop_front();
                if (rs_vld[p])
                    checkOutput($sformatf("%s_data%0d", tag, p), 64'(rs_data[p*XLEN +: XLEN]), 64'(expv));
            end
        end
    endtask

    initial begin
        RSTN = 1'b0;
        idle();
        tick();
        tick();
        checkOutput("reset_data", 64'(rs_data), 64'h0);
        checkOutput("reset_vld", 64'(rs_vld), 64'h0);
        checkOutput("reset_busy", 64'(rs_busy), 64'h0);
        RSTN = 1'b1;
        tick();

        $display("[TB] write x5 then read it on port 0");
        applyStimulus(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0, 2'b00, 0, 0);
        tick();
        applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 2'b01, 5, 0);
        q0.push_back(32'hDEADBEEF);
        #1 checkOutput("x5_busy", 64'(rs_busy), 64'h0);
        tick();
        checkPorts("x5_read");
        idle();
        tick();
        checkPorts("x5_pulse_end");

        $display("[TB] same register on both ports");
        applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 2'b11, 5, 5);
        q0.push_back(32'hDEADBEEF);
        q1.push_back(32'hDEADBEEF);
        tick();
        checkPorts("x5_dual");

        $display("[TB] x0 stays zero");
        applyStimulus(1'b1, 0, 32'h1234, 1'b0, 0, 1'b0, 2'b00, 0, 0);
        tick();
        applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 2'b11, 0, 0);
        q0.push_back('0);
        q1.push_back('0);
        #1 checkOutput("x0_busy", 64'(rs_busy), 64'h0);
        tick();
        checkPorts("x0_read");

        $display("[TB] pending x7 stalls until written");
        applyStimulus(1'b0, 0, '0, 1'b1, 7, 1'b0, 2'b00, 0, 0);
        tick();
        applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 2'b01, 7, 0);
        #1 checkOutput("x7_busy_a", 64'(rs_busy[0]), 64'h1);
        tick();
        checkPorts("x7_stall_a");
        #1 checkOutput("x7_busy_b", 64'(rs_busy[0]), 64'h1);
        tick();
        checkPorts("x7_stall_b");
        applyStimulus(1'b1, 7, 32'h55, 1'b0, 0, 1'b0, 2'b01, 7, 0);
        if (BYP) q0.push_back(32'h55);
        #1 checkOutput("x7_busy_wr", 64'(rs_busy[0]), BYP ? 64'h0 : 64'h1);
        tick();
        checkPorts("x7_wr_cycle");
        applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, BYP ? 2'b00 : 2'b01, 7, 0);
        if (!BYP) q0.push_back(32'h55);
        #1 checkOutput("x7_busy_after", 64'(rs_busy[0]), 64'h0);
        tick();
        checkPorts("x7_read");

        $display("[TB] same-cycle write and read of x3");
        applyStimulus(1'b1, 3, 32'h1, 1'b0, 0, 1'b0, 2'b00, 0, 0);
        tick();
        applyStimulus(1'b1, 3, 32'hA5A5A5A5, 1'b0, 0, 1'b0, 2'b01, 3, 0);
        q0.push_back(BYP ? 32'hA5A5A5A5 : 32'h1);
        #1 checkOutput("x3_busy", 64'(rs_busy[0]), 64'h0);
        tick();
        checkPorts("x3_hit");
        applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 2'b10, 0, 3);
        q1.push_back(32'hA5A5A5A5);
        tick();
        checkPorts("x3_after");

        $display("[TB] flush clears pending marks and blocks alloc");
        applyStimulus(1'b0, 0, '0, 1'b1, 9, 1'b0, 2'b00, 0, 0);
        tick();
        applyStimulus(1'b0, 0, '0, 1'b1, 10, 1'b0, 2'b00, 9, 10);
        tick();
        #1 checkOutput("x9_x10_busy", 64'(rs_busy), 64'h3);
        applyStimulus(1'b0, 0, '0, 1'b1, 11, 1'b1, 2'b00, 9, 10);
        tick();
        #1 checkOutput("flush_busy", 64'(rs_busy), 64'h0);
        applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 2'b00, 11, 0);
        #1 checkOutput("flush_alloc_x11", 64'(rs_busy[0]), 64'h0);
        applyStimulus(1'b1, 4, 32'h44, 1'b1, 4, 1'b0, 2'b00, 0, 0);
        tick();
        applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 2'b00, 4, 4);
        #1 checkOutput("x4_still_busy", 64'(rs_busy), 64'h3);

        $display("[TB] reset during an accepted read");
        applyStimulus(1'b1, 6, 32'h77, 1'b0, 0, 1'b0, 2'b00, 0, 0);
        tick();
        applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 2'b01, 6, 4);
        #1 checkOutput("x6_busy", 64'(rs_busy[0]), 64'h0);
        #3 RSTN = 1'b0;
        tick();
        checkOutput("rst_data", 64'(rs_data), 64'h0);
        checkOutput("rst_vld", 64'(rs_vld), 64'h0);
        checkOutput("rst_busy", 64'(rs_busy), 64'h0);
        applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 2'b00, 6, 4);
        RSTN = 1'b1;
        tick();
        checkPorts("post_rst_idle");
        checkOutput("post_rst_x4_busy", 64'(rs_busy[1]), 64'h0);
        applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 2'b01, 6, 4);
        q0.push_back('0);
        tick();
        checkPorts("post_rst_x6");
        idle();
        tick();
        checkPorts("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
